// File: rtl/alu_issue_stage.sv
// Purpose : registered RV32I issue stage; decodes one instruction into ALU controls/operands.
// Latency : 1 cycle; an instruction accepted at edge N is presented after edge N.
// Backpressure: in_ready = ~out_valid | out_ready; outputs hold while out_valid & ~out_ready.
//
// Ports: clk/rst_n (async active-low); in_valid/in_ready + instr/pc/rs1_data/rs2_data upstream;
//        flush kills held and incoming; out_valid/out_ready + opA/opB/S/M/Cin/rd/rd_we/out_pc/illegal.
// Optional: `define ISSUE_FWD_EN adds fwd_valid/fwd_rd/fwd_data bypass onto rs1/rs2.
module alu_issue_stage #(
  parameter int                XLEN         = 32,
  parameter logic [XLEN-1:0]   RESET_PC_TAG = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
`ifdef ISSUE_FWD_EN
  input  logic            fwd_valid,
  input  logic [4:0]      fwd_rd,
  input  logic [XLEN-1:0] fwd_data,
`endif
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] opA,
  output logic [XLEN-1:0] opB,
  output logic [3:0]      S,
  output logic            M,
  output logic            Cin,
  output logic [4:0]      rd,
  output logic            rd_we,
  output logic [XLEN-1:0] out_pc,
  output logic            illegal
);

  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [XLEN-1:0] opa;
    logic [XLEN-1:0] opb;
    logic [3:0]      s;
    logic            m;
    logic            cin;
    logic [4:0]      rd;
    logic            rd_we;
    logic            illegal;
  } issue_t;

  // funct3 -> {supported, S, M} shared by the R-type and I-type forms (ADD/AND/OR/XOR).
  function automatic logic [5:0] alu_sel(input logic [2:0] f3);
    case (f3)
      3'b000:  alu_sel = {1'b1, 4'b1001, 1'b1};
      3'b111:  alu_sel = {1'b1, 4'b1000, 1'b0};
      3'b110:  alu_sel = {1'b1, 4'b1110, 1'b0};
      3'b100:  alu_sel = {1'b1, 4'b0110, 1'b0};
      default: alu_sel = 6'b0;
    endcase
  endfunction

  issue_t          dec;
  issue_t          q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] src1, src2;
  logic [XLEN-1:0] imm_i, imm_u;
  logic [5:0]      sel;
  logic            bad;
  logic [6:0]      opc, f7;
  logic [2:0]      f3;

  assign opc   = instr[6:0];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];
  assign imm_i = {{(XLEN-12){instr[31]}}, instr[31:20]};
  assign imm_u = {instr[31:12], 12'b0};
  assign sel   = alu_sel(f3);

  always_comb begin
    src1 = rs1_data;
    src2 = rs2_data;
`ifdef ISSUE_FWD_EN
    if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[19:15]) src1 = fwd_data;
    if (fwd_valid && fwd_rd != 5'd0 && fwd_rd == instr[24:20]) src2 = fwd_data;
`endif
  end

  always_comb begin
    dec    = '0;
    dec.rd = instr[11:7];
    bad    = 1'b0;
    case (opc)
      OPC_R: begin
        dec.opa = src1;
        dec.opb = src2;
        if (f7 == 7'b0000000 && sel[5]) begin
          dec.s = sel[4:1];
          dec.m = sel[0];
        end else if (f7 == 7'b0100000 && f3 == 3'b000) begin
          // SUB as A + ~B + 1; inversion happens after any forwarding.
          dec.opb = ~src2;
          dec.s   = 4'b1001;
          dec.m   = 1'b1;
          dec.cin = 1'b1;
        end else begin
          bad = 1'b1;
        end
      end
      OPC_I: begin
        dec.opa = src1;
        dec.opb = imm_i;
        dec.s   = sel[4:1];
        dec.m   = sel[0];
        bad     = ~sel[5];
      end
      OPC_LUI: begin
        dec.opb = imm_u;
        dec.s   = 4'b1010;
      end
      OPC_AUIPC: begin
        dec.opa = pc;
        dec.opb = imm_u;
        dec.s   = 4'b1001;
        dec.m   = 1'b1;
      end
      default: bad = 1'b1;
    endcase
    // Unsupported instructions still issue, but as a zeroed bubble flagged for trapping.
    if (bad) begin
      dec         = '0;
      dec.rd      = instr[11:7];
      dec.illegal = 1'b1;
    end else begin
      dec.rd_we = (instr[11:7] != 5'd0);
    end
  end

  assign in_ready = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      q         <= '0;
      pc_q      <= RESET_PC_TAG;
    end else if (flush) begin
      out_valid <= 1'b0;
      q.rd_we   <= 1'b0;
      q.illegal <= 1'b0;
    end else if (in_valid && in_ready) begin
      out_valid <= 1'b1;
      q         <= dec;
      pc_q      <= pc;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  assign opA     = q.opa;
  assign opB     = q.opb;
  assign S       = q.s;
  assign M       = q.m;
  assign Cin     = q.cin;
  assign rd      = q.rd;
  assign rd_we   = q.rd_we;
  assign illegal = q.illegal;
  assign out_pc  = pc_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

  logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0] instr, pc, rs1_data, rs2_data, opA, opB, out_pc;
  logic [3:0]  S;
  logic        M, Cin, rd_we, illegal;
  logic [4:0]  rd;
`ifdef ISSUE_FWD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int checks = 0;
  int errors = 0;

  alu_issue_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instr(instr), .pc(pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ISSUE_FWD_EN
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data),
`endif
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .opA(opA), .opB(opB), .S(S), .M(M), .Cin(Cin), .rd(rd), .rd_we(rd_we),
    .out_pc(out_pc), .illegal(illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model of the held instruction.
  logic        m_valid, m_m, m_cin, m_we, m_ill;
  logic [31:0] m_opa, m_opb, m_pc;
  logic [3:0]  m_s;
  logic [4:0]  m_rd;

  typedef enum {K_ILL, K_ADD, K_SUB, K_AND, K_OR, K_XOR, K_LUI, K_AUIPC} kind_t;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_valid = 0; m_opa = 0; m_opb = 0; m_s = 0; m_m = 0; m_cin = 0;
    m_rd = 0; m_we = 0; m_ill = 0; m_pc = 32'h0;
  endtask

  task automatic m_load();
    kind_t       k;
    logic [31:0] a, b, immi;
    int          v;
    a = rs1_data;
    b = rs2_data;
`ifdef ISSUE_FWD_EN
    if (fwd_valid && fwd_rd != 0 && fwd_rd == instr[19:15]) a = fwd_data;
    if (fwd_valid && fwd_rd != 0 && fwd_rd == instr[24:20]) b = fwd_data;
`endif
    v = int'(instr[31:20]);
    if (v > 2047) v = v - 4096;
    immi = 32'(v);
    k = K_ILL;
    if (instr[6:0] == 7'h33 || instr[6:0] == 7'h13) begin
      case (instr[14:12])
        3'd0: k = K_ADD;
        3'd7: k = K_AND;
        3'd6: k = K_OR;
        3'd4: k = K_XOR;
        default: k = K_ILL;
      endcase
      if (instr[6:0] == 7'h33) begin
        if (instr[31:25] == 7'h20 && k == K_ADD) k = K_SUB;
        else if (instr[31:25] != 7'h00) k = K_ILL;
      end else begin
        b = immi;  // I-type: same operation with the immediate as operand B
      end
    end else if (instr[6:0] == 7'h37) k = K_LUI;
    else if (instr[6:0] == 7'h17) k = K_AUIPC;

    m_opa = a; m_opb = b; m_cin = 0; m_ill = 0;
    case (k)
      K_ADD:   begin m_s = 4'h9; m_m = 1; end
      K_SUB:   begin m_s = 4'h9; m_m = 1; m_opb = 32'hFFFF_FFFF - b; m_cin = 1; end
      K_AND:   begin m_s = 4'h8; m_m = 0; end
      K_OR:    begin m_s = 4'hE; m_m = 0; end
      K_XOR:   begin m_s = 4'h6; m_m = 0; end
      K_LUI:   begin m_s = 4'hA; m_m = 0; m_opa = 0; m_opb = instr & 32'hFFFF_F000; end
      K_AUIPC: begin m_s = 4'h9; m_m = 1; m_opa = pc; m_opb = instr & 32'hFFFF_F000; end
      default: begin m_s = 0; m_m = 0; m_opa = 0; m_opb = 0; m_ill = 1; end
    endcase
    m_rd    = instr[11:7];
    m_we    = !m_ill && (m_rd != 0);
    m_pc    = pc;
    m_valid = 1;
  endtask

  // Advance one clock edge; the model sees the same inputs the DUT sampled.
  task automatic tick();
    @(posedge clk);
    if (!rst_n) m_reset();
    else if (flush) begin m_valid = 0; m_we = 0; m_ill = 0; end
    else if (in_valid && (!m_valid || out_ready)) m_load();
    else if (out_ready) m_valid = 0;
    #1;
  endtask

  task automatic drv(input logic v, input logic [31:0] i, input logic [31:0] p,
                     input logic [31:0] r1, input logic [31:0] r2);
    in_valid = v; instr = i; pc = p; rs1_data = r1; rs2_data = r2;
  endtask

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      cmp("in_ready",  32'(in_ready),  32'(!m_valid || out_ready));
      cmp("out_valid", 32'(out_valid), 32'(m_valid));
      cmp("opA",       opA,            m_opa);
      cmp("opB",       opB,            m_opb);
      cmp("S",         32'(S),         32'(m_s));
      cmp("M",         32'(M),         32'(m_m));
      cmp("Cin",       32'(Cin),       32'(m_cin));
      cmp("rd",        32'(rd),        32'(m_rd));
      cmp("rd_we",     32'(rd_we),     32'(m_we));
      cmp("illegal",   32'(illegal),   32'(m_ill));
      cmp("out_pc",    out_pc,         m_pc);
    end
  end

  logic [31:0] vec [12];

  initial begin
    m_reset();
    rst_n = 0; flush = 0; out_ready = 0;
    drv(0, 0, 0, 0, 0);
`ifdef ISSUE_FWD_EN
    fwd_valid = 0; fwd_rd = 0; fwd_data = 0;
`endif
    #7;
    cmp("rst_out_valid", 32'(out_valid), 0);
    cmp("rst_opA", opA, 0);
    cmp("rst_S", 32'(S), 0);
    cmp("rst_out_pc", out_pc, 32'h0);
    rst_n = 1; out_ready = 1;

    // ADD x3,x1,x2
    drv(1, 32'h002081B3, 32'h100, 5, 7); tick();
    cmp("add_valid", 32'(out_valid), 1);
    cmp("add_opA", opA, 5);
    cmp("add_opB", opB, 7);
    cmp("add_S", 32'(S), 32'h9);
    cmp("add_M", 32'(M), 1);
    cmp("add_Cin", 32'(Cin), 0);
    cmp("add_rd", 32'(rd), 3);
    cmp("add_rd_we", 32'(rd_we), 1);
    // SUB x3,x1,x2
    drv(1, 32'h402081B3, 32'h104, 5, 7); tick();
    cmp("sub_opB", opB, 32'hFFFF_FFF8);
    cmp("sub_Cin", 32'(Cin), 1);
    cmp("sub_S", 32'(S), 32'h9);
    // ADDI x1,x0,-1 then LUI x5,0x12345 back to back
    drv(1, 32'hFFF00093, 32'h108, 0, 0); tick();
    cmp("addi_opB", opB, 32'hFFFF_FFFF);
    cmp("addi_S", 32'(S), 32'h9);
    drv(1, 32'h123452B7, 32'h10C, 32'h55, 0); tick();
    cmp("lui_opA", opA, 0);
    cmp("lui_opB", opB, 32'h1234_5000);
    cmp("lui_S", 32'(S), 32'hA);
    cmp("lui_M", 32'(M), 0);

    // Logic ops, I-forms with negative immediates, AUIPC, and unsupported encodings.
    vec[0]  = 32'h0020F1B3;  // AND
    vec[1]  = 32'h0020E1B3;  // OR
    vec[2]  = 32'h0020C1B3;  // XOR
    vec[3]  = 32'h8000F193;  // ANDI imm=-2048
    vec[4]  = 32'hF0F0E193;  // ORI  imm=-241
    vec[5]  = 32'h7FF0C193;  // XORI imm=2047
    vec[6]  = 32'h00001197;  // AUIPC x3,1
    vec[7]  = 32'h002091B3;  // SLL (unsupported)
    vec[8]  = 32'h0020A193;  // SLTI (unsupported)
    vec[9]  = 32'h4020D1B3;  // SRA (unsupported)
    vec[10] = 32'h022081B3;  // MUL (unsupported)
    vec[11] = 32'h00008093;  // ADDI x1,x1,0
    for (int i = 0; i < 12; i++) begin
      drv(1, vec[i], 32'h200 + 32'(4 * i), 32'hF0F0_1234, 32'h0FF0_8765);
      tick();
    end

    // Illegal and x0 destination
    drv(1, 32'h00000073, 32'h300, 9, 9); tick();
    cmp("ill_flag", 32'(illegal), 1);
    cmp("ill_rd_we", 32'(rd_we), 0);
    cmp("ill_valid", 32'(out_valid), 1);
    cmp("ill_opA", opA, 0);
    drv(1, 32'h00208033, 32'h304, 1, 2); tick();
    cmp("x0_rd_we", 32'(rd_we), 0);
    cmp("x0_illegal", 32'(illegal), 0);

    // Stall: A held, B pending for 3 cycles, then issues exactly once.
    drv(1, 32'h002081B3, 32'h400, 32'h11, 1); tick();
    out_ready = 0;
    drv(1, 32'h0020C1B3, 32'h404, 32'h22, 32'h33);
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp("stall_in_ready", 32'(in_ready), 0);
      cmp("stall_opA", opA, 32'h11);
      cmp("stall_pc", out_pc, 32'h400);
    end
    out_ready = 1; tick();
    cmp("rel_opA", opA, 32'h22);
    cmp("rel_S", 32'(S), 32'h6);
    in_valid = 0; tick();
    cmp("rel_once", 32'(out_valid), 0);

    // Flush beats a simultaneous transfer.
    drv(1, 32'h002081B3, 32'h500, 3, 4); flush = 1; tick();
    cmp("flush_in_valid", 32'(out_valid), 0);
    cmp("flush_rd_we", 32'(rd_we), 0);
    flush = 0; tick();
    // Flush of a held, stalled instruction.
    out_ready = 0; in_valid = 0; flush = 1; tick();
    cmp("flush_held", 32'(out_valid), 0);
    flush = 0; out_ready = 1;
    drv(1, 32'h00000073, 32'h508, 0, 0); tick();
    flush = 1; in_valid = 0; tick();
    cmp("flush_illegal", 32'(illegal), 0);
    flush = 0;

    // Reset mid-stall takes effect without a clock edge.
    drv(1, 32'h002081B3, 32'h600, 6, 7); tick();
    out_ready = 0;
    drv(1, 32'h402081B3, 32'h604, 8, 9); tick(); tick();
    #2 rst_n = 0;
    #1;
    cmp("arst_valid", 32'(out_valid), 0);
    cmp("arst_opA", opA, 0);
    cmp("arst_opB", opB, 0);
    cmp("arst_rd_we", 32'(rd_we), 0);
    cmp("arst_pc", out_pc, 32'h0);
    m_reset();
    tick();
    rst_n = 1; out_ready = 1; in_valid = 0;
    tick();
    cmp("post_rst_valid", 32'(out_valid), 0);
    drv(1, 32'h002081B3, 32'h700, 32'hA, 32'hB); tick();
    cmp("post_rst_opA", opA, 32'hA);

`ifdef ISSUE_FWD_EN
    fwd_valid = 1; fwd_rd = 1; fwd_data = 32'h10;
    drv(1, 32'h002081B3, 32'h800, 5, 7); tick();
    cmp("fwd_opA", opA, 32'h10);
    cmp("fwd_opB", opB, 7);
    fwd_rd = 2;
    drv(1, 32'h402081B3, 32'h804, 5, 7); tick();
    cmp("fwd_sub_opB", opB, 32'hFFFF_FFEF);
    fwd_rd = 1;
    drv(1, 32'h00008197, 32'h808, 5, 7); tick();
    cmp("fwd_auipc_opA", opA, 32'h808);
    fwd_valid = 0;
`endif

    in_valid = 0; tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Registered issue stage directly upstream of the execute ALU.
- Accepts a decoded-ready RV32I instruction with its PC and register-file read data.
- Decodes it into ALU controls (S, M, Cin) and operands (opA, opB), then holds them in one pipeline register with valid/ready handshake, stall and flush.
- Unsupported opcodes issue as flagged bubbles.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC_TAG, 32'h0000_0000, reset value of out_pc.

Ports:
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream instruction valid
- in_ready  output  1  stage can accept
- instr  input  32  instruction word
- pc  input  32  instruction PC
- rs1_data  input  32  register-file read of instr[19:15]
- rs2_data  input  32  register-file read of instr[24:20]
- flush  input  1  kill held and incoming instruction
- out_valid  output  1  ALU operands valid
- out_ready  input  1  ALU/downstream accepts
- opA  output  32  ALU operand A
- opB  output  32  ALU operand B
- S  output  4  ALU operation select
- M  output  1  0 = logical, 1 = arithmetic
- Cin  output  1  ALU carry in
- rd  output  5  destination register
- rd_we  output  1  write-back enable
- out_pc  output  32  PC of held instruction
- illegal  output  1  held instruction unsupported

Behaviour:
- Reset: asynchronous, active-low on rst_n, single clock clk. While rst_n=0:
  - out_valid=0, opA=opB=0, S=4'b0000, M=0, Cin=0, rd=0, rd_we=0, illegal=0, out_pc=RESET_PC_TAG.
- Handshake:
  - in_ready = ~out_valid | out_ready (combinational).
  - Transfer occurs when in_valid & in_ready.
  - Output fields are held stable while out_valid & ~out_ready.
- Latency: one cycle, instruction accepted at edge N appears at outputs after edge N.
- Register update at each edge:
  - flush=1: out_valid<=0, rd_we<=0, illegal<=0. Flush takes priority over a simultaneous transfer; the incoming instruction is dropped.
  - Else on transfer: load decoded fields, out_valid<=1.
  - Else if out_ready: out_valid<=0.
  - Else hold.
- Decode (immediates sign-extended to 32 bits):
  - ADD (op 0110011, f3 000, f7 0000000): opA=rs1, opB=rs2, S=1001, M=1, Cin=0.
  - SUB (f7 0100000): opA=rs1, opB=~rs2, S=1001, M=1, Cin=1, giving A+~B+1.
  - AND/OR/XOR (f3 111/110/100, f7 0): S=1000/1110/0110, M=0, Cin=0.
  - ADDI/ANDI/ORI/XORI (op 0010011): same S/M as the R-type form, opB=I-imm.
  - LUI (0110111): opA=0, opB={instr[31:12],12'b0}, S=1010, M=0.
  - AUIPC (0010111): opA=pc, opB=U-imm, ADD encoding.
  - rd_we=1 for all the above, except rd_we=0 when rd=0.
  - Anything else: illegal=1, rd_we=0, S=0000, M=0, Cin=0, opA=opB=0. It still issues out_valid=1 so downstream can trap.
- Stall boundary: in_valid held high while stalled must not cause a double issue; each transfer issues exactly once.
- Reset mid-stall discards the held instruction.

Optional Feature:
- Macro ISSUE_FWD_EN.
- Defined:
  - Adds inputs fwd_valid (1), fwd_rd (5), fwd_data (32).
  - On transfer, if fwd_valid & fwd_rd!=0 & fwd_rd==rs1 field, use fwd_data in place of rs1_data.
  - Same rule for rs2, applied before the SUB inversion.
  - AUIPC and LUI ignore forwarding for opA.
- Undefined: ports absent, register-file data always used.

Test Plan:
- ADD, instr=0x002081B3, rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, opA=5, opB=7, S=1001, M=1, Cin=0, rd=3, rd_we=1.
- SUB, instr=0x402081B3, same data -> opB=0xFFFFFFF8, Cin=1, S=1001, M=1.
- ADDI x1,x0,-1 (0xFFF00093), then LUI x5,0x12345 (0x123452B7) back-to-back -> first opB=0xFFFFFFFF, S=1001; then opA=0, opB=0x12345000, S=1010, M=0.
- Stall and flush:
  - Hold out_ready=0 for 3 cycles with a new in_valid pending -> in_ready=0 and outputs stable.
  - Release -> next instruction issues once.
  - Assert flush with in_valid -> out_valid=0 next cycle.
- Illegal and x0: instr=0x00000073 -> illegal=1, rd_we=0, out_valid=1. ADD x0,x1,x2 (0x00208033) -> rd_we=0.
- Reset and forwarding:
  - Drive rst_n low mid-stall -> all outputs reset immediately, without waiting for clk.
  - With ISSUE_FWD_EN: fwd_rd=1, fwd_data=0x10, ADD x3,x1,x2 -> opA=0x10.
